celda_tipica: RTL and testbench
===============================

Name: celda_tipica

Overview:
- Typical cell of the left-to-right (MSB-first) iterative magnitude comparator.
- Compares operand slices A and B under a 2-bit mode (y,z): greater-than, less-than or equality.
- Accepts an upstream "equal so far" chain input g_in.
- Produces a result flag f_mid and a downstream chain output g_mid.
- Outputs are registered so cells can be pipelined in the comparator array.

Parameters:
- WIDTH, 1, number of operand bits per cell. WIDTH=1 is the single-bit cell; larger values cascade WIDTH bit slices internally, MSB first.

Ports:
- clk  input  1  system clock; all outputs update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- z  input  1  mode select bit 0.
- y  input  1  mode select bit 1.
- g_in  input  1  upstream chain: 1 = all more-significant bits so far are equal and the comparison is still undecided.
- A  input  WIDTH  operand A slice; bit WIDTH-1 is the most significant.
- B  input  WIDTH  operand B slice; bit WIDTH-1 is the most significant.
- f_mid  output  1  registered result flag for the selected mode.
- g_mid  output  1  registered downstream chain (equal so far, including this cell).

Behaviour:
- Reset: while rst=1, f_mid=0 and g_mid=0 immediately, regardless of clk. Both outputs are held at 0 until the first rising clk edge after rst deasserts.
- Latency: exactly 1 clock. The outputs reflect the inputs sampled at the rising edge. No handshake; a new input set is accepted every cycle.
- Slice chain, combinational, processed from bit i=WIDTH-1 down to 0:
  - e[WIDTH] = g_in
  - e[i] = e[i+1] & ~(A[i]^B[i])
  - gt[i] = e[i+1] & A[i] & ~B[i]
  - lt[i] = e[i+1] & ~A[i] & B[i]
- Next g_mid = e[0] in every active mode. In mode 00, g_mid=0.
- Next f_mid by mode {y,z}:
  - 01 (greater-than): OR of gt[i] over all slices.
  - 10 (less-than): OR of lt[i] over all slices.
  - 11 (equality): e[0].
  - 00 (idle/disabled): 0.
- g_in=0 means the decision was already made upstream. In that case f_mid=0 and g_mid=0 for every mode and every A,B.
- At most one gt[i] or lt[i] can be 1 per evaluation; the first differing bit kills the chain.
- Mode changes take effect on the next rising edge; there are no mode-transition hazards beyond the register.
- If rst asserts mid-operation, the outputs clear immediately and the in-flight result is discarded.
- No X propagation from the idle mode: the outputs are fully defined for all 32 input combinations at WIDTH=1.

Decomposition:
- Shared package:
  - mode localparams MODE_IDLE=2'b00, MODE_GT=2'b01, MODE_LT=2'b10, MODE_EQ=2'b11
  - a typedef for the 2-bit mode {y,z}
- Sub-module celda_bit, purely combinational single-bit slice:
  - inputs e_in, a, b
  - outputs e_out, gt, lt
- celda_tipica instantiates WIDTH celda_bit slices in a generate loop, plus the mode mux and the output register.

Test Plan:
- Reset: rst=1 with arbitrary inputs -> f_mid=0 and g_mid=0 asynchronously, and they stay 0 through clock edges until rst=0.
- GT mode, WIDTH=1: y=0, z=1, sweep all 8 (A,B,g_in) -> the cycle after each:
  - f_mid=1 only for A=1, B=0, g_in=1.
  - g_mid=1 only for A=B with g_in=1.
- LT mode, WIDTH=1: y=1, z=0, sweep all 8 -> f_mid=1 only for A=0, B=1, g_in=1; g_mid as in the GT case.
- EQ mode, WIDTH=1: y=1, z=1, sweep all 8 -> f_mid=g_mid=1 only for (0,0,1) and (1,1,1); otherwise both 0.
- Idle and chain kill:
  - y=0, z=0 with A=1, B=0, g_in=1 -> f_mid=0, g_mid=0.
  - Any mode with g_in=0 -> f_mid=0, g_mid=0.
- WIDTH=3 cascade: GT mode, A=3'b101, B=3'b100, g_in=1 -> f_mid=1, g_mid=0.
  - Then A=3'b011, B=3'b100 -> f_mid=0, g_mid=0.
  - Then EQ mode, A=B=3'b110 -> f_mid=1, g_mid=1.

Source files
------------

// File: rtl/celda_tipica_pkg.sv
// Shared types and constants for the iterative magnitude comparator cell.
// Defines the {y,z} mode encoding used by celda_tipica.
package celda_tipica_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_IDLE = 2'b00;
    localparam mode_t MODE_GT   = 2'b01;
    localparam mode_t MODE_LT   = 2'b10;
    localparam mode_t MODE_EQ   = 2'b11;

endpackage

// File: rtl/celda_tipica_bit.sv
// Single-bit combinational slice of the MSB-first comparator chain.
// Ports: e_in (equal so far), a, b -> e_out, gt, lt.
module celda_bit (
    input  logic e_in,
    input  logic a,
    input  logic b,
    output logic e_out,
    output logic gt,
    output logic lt
);

    assign e_out = e_in & ~(a ^ b);
    assign gt    = e_in & a & ~b;
    assign lt    = e_in & ~a & b;

endmodule

// File: rtl/celda_tipica.sv
// Typical comparator cell: WIDTH-bit MSB-first slice chain with registered result.
// Ports: clk, rst (async high), z/y mode, g_in chain in, A/B operands -> f_mid, g_mid.
module celda_tipica
    import celda_tipica_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             y,
    input  logic             g_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             f_mid,
    output logic             g_mid
);

    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] gt;
    logic [WIDTH-1:0] lt;
    mode_t            mode;
    logic             f_nxt;
    logic             g_nxt;

    assign e[WIDTH] = g_in;
    assign mode     = {y, z};

    // Equality ripples from the MSB down; first difference kills the chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        celda_bit u_bit (
            .e_in  (e[i+1]),
            .a     (A[i]),
            .b     (B[i]),
            .e_out (e[i]),
            .gt    (gt[i]),
            .lt    (lt[i])
        );
    end

    always_comb begin
        f_nxt = 1'b0;
        g_nxt = 1'b0;
        case (mode)
            MODE_GT: begin
                f_nxt = |gt;
                g_nxt = e[0];
            end
            MODE_LT: begin
                f_nxt = |lt;
                g_nxt = e[0];
            end
            MODE_EQ: begin
                f_nxt = e[0];
                g_nxt = e[0];
            end
            default: begin
                f_nxt = 1'b0;
                g_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_mid <= 1'b0;
            g_mid <= 1'b0;
        end else begin
            f_mid <= f_nxt;
            g_mid <= g_nxt;
        end
    end

endmodule

// File: tb/tb_celda_tipica.sv
// Self-checking bench for celda_tipica at WIDTH=1 and WIDTH=3.
// Expected {f_mid,g_mid} pairs are queued at drive time and popped after the edge.
module tb_celda_tipica;

    logic       clk = 1'b0;
    logic       rst;
    logic       y;
    logic       z;
    logic       g_in;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       f1, g1, f3, g3;

    int errors = 0;
    int checks = 0;

    logic [1:0] q1[$];
    logic [1:0] q3[$];

    always #5 clk = ~clk;

    celda_tipica #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst   (rst),
        .z     (z),
        .y     (y),
        .g_in  (g_in),
        .A     (a1),
        .B     (b1),
        .f_mid (f1),
        .g_mid (g1)
    );

    celda_tipica #(.WIDTH(3)) u_w3 (
        .clk   (clk),
        .rst   (rst),
        .z     (z),
        .y     (y),
        .g_in  (g_in),
        .A     (a3),
        .B     (b3),
        .f_mid (f3),
        .g_mid (g3)
    );

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {f,g}=%b expected %b at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: plain magnitude comparison of the operands.
    function automatic logic [1:0] model(input logic [1:0] m,
                                         input logic g,
                                         input int unsigned a,
                                         input int unsigned b);
        logic f;
        logic eq;
        if (!g || m == 2'b00) return 2'b00;
        eq = (a == b);
        case (m)
            2'b01:   f = (a > b);
            2'b10:   f = (a < b);
            default: f = eq;
        endcase
        return {f, eq};
    endfunction

    task automatic step(input string tag, input logic yy, input logic zz,
                        input logic gg, input logic aa1, input logic bb1,
                        input logic [2:0] aa3, input logic [2:0] bb3);
        @(negedge clk);
        y    = yy;
        z    = zz;
        g_in = gg;
        a1   = aa1;
        b1   = bb1;
        a3   = aa3;
        b3   = bb3;
        q1.push_back(model({yy, zz}, gg, 32'(aa1), 32'(bb1)));
        q3.push_back(model({yy, zz}, gg, 32'(aa3), 32'(bb3)));
        @(posedge clk);
        #1;
        if (q1.size() == 0 || q3.size() == 0) begin
            chk({tag, "_empty"}, 2'b11, 2'b00);
        end else begin
            chk({tag, "_w1"}, {f1, g1}, q1.pop_front());
            chk({tag, "_w3"}, {f3, g3}, q3.pop_front());
        end
    endtask

    initial begin
        rst  = 1'b1;
        y    = 1'b1;
        z    = 1'b1;
        g_in = 1'b1;
        a1   = 1'b1;
        b1   = 1'b1;
        a3   = 3'b111;
        b3   = 3'b111;
        #1;
        chk("rst_async_w1", {f1, g1}, 2'b00);
        chk("rst_async_w3", {f3, g3}, 2'b00);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_w1", {f1, g1}, 2'b00);
            chk("rst_hold_w3", {f3, g3}, 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_w1", {f1, g1}, 2'b00);

        // Exhaustive single-bit sweep in every mode.
        for (int m = 0; m < 4; m++) begin
            for (int v = 0; v < 8; v++) begin
                logic [2:0] vv;
                logic [1:0] mm;
                vv = 3'(v);
                mm = 2'(m);
                step("sweep", mm[1], mm[0], vv[2], vv[1], vv[0],
                     {vv[1], 2'b00}, {vv[0], 2'b00});
            end
        end

        // Idle with a would-be greater-than pattern.
        step("idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101, 3'b100);

        // WIDTH=3 cascade cases.
        step("casc_gt", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 3'b100);
        chk("casc_gt_exact", {f3, g3}, 2'b10);
        step("casc_lt", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b100);
        chk("casc_lt_exact", {f3, g3}, 2'b00);
        step("casc_eq", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 3'b110);
        chk("casc_eq_exact", {f3, g3}, 2'b11);

        // Randomised multi-bit vectors across all modes.
        for (int k = 0; k < 40; k++) begin
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom),
                 3'($urandom), 3'($urandom));
        end

        // Mid-operation reset discards a live result.
        step("pre_rst", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b011);
        chk("pre_rst_live", {f1, f3}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_w1", {f1, g1}, 2'b00);
        chk("mid_rst_w3", {f3, g3}, 2'b00);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", {f1, g1, f3, g3} == 4'b0000 ? 2'b00 : 2'b11, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
